// File: rtl/file_write_arbiter.sv
// Round-robin arbiter for the single write port of the register file, with a
// zero-clearing sweep after reset or init. Optional stall counter: FILE_WRITE_ARBITER_STALL_CNT_EN.
module file_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid_in,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data_in,
    output logic [NUM_REQ-1:0]             req_ready_out,
    input  logic                           init_in,
    output logic                           busy_out,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id_out,
    output logic [ADDR_WIDTH-1:0]          write_addr_out,
    output logic                           write_out,
    output logic [DATA_WIDTH-1:0]          write_data_out,
    output logic [15:0]                    stall_count_out,
    input  logic                           debugen_in
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    typedef enum logic {CLEAR, ARB} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [IDW-1:0]        grant_id_q, grant_id_d;

    logic                  found;
    logic                  grant_ok;
    logic [IDW-1:0]        grant_idx;
    logic [IDW-1:0]        idx;
    logic [NUM_REQ-1:0]    grant_oh;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // Search starts at rr_ptr and wraps; NUM_REQ is a power of two so IDW-bit addition wraps for free.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        found     = 1'b0;
        grant_idx = '0;
        idx       = '0;
        grant_oh  = '0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = rr_ptr_q + IDW'(off);
            if (!found && req_valid_in[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
        grant_ok = found && (state_q == ARB) && !init_in;
        if (grant_ok) grant_oh[grant_idx] = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                sel_addr = req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        rr_ptr_d   = rr_ptr_q;
        write_d    = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        grant_id_d = grant_id_q;
        unique case (state_q)
            CLEAR: begin
                write_d = 1'b1;
                waddr_d = clr_addr_q;
                wdata_d = '0;
                if (init_in) begin
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                    if (clr_addr_q == LAST_ADDR) state_d = ARB;
                end
            end
            ARB: begin
                if (init_in) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end else if (grant_ok) begin
                    write_d    = 1'b1;
                    waddr_d    = sel_addr;
                    wdata_d    = sel_data;
                    grant_id_d = grant_idx;
                    rr_ptr_d   = grant_idx + IDW'(1);
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            rr_ptr_q   <= '0;
            write_q    <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            grant_id_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            rr_ptr_q   <= rr_ptr_d;
            write_q    <= write_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign req_ready_out  = grant_oh;
    assign busy_out       = (state_q == CLEAR);
    assign grant_id_out   = grant_id_q;
    assign write_out      = write_q;
    assign write_addr_out = waddr_q;
    assign write_data_out = wdata_q;

`ifdef FILE_WRITE_ARBITER_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // One count per ARB cycle in which any valid requester is left waiting; saturates.
    always_comb begin
        stall_d = stall_q;
        if (init_in)
            stall_d = '0;
        else if ((state_q == ARB) && |(req_valid_in & ~req_ready_out) && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_count_out = stall_q;
`else
    assign stall_count_out = '0;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (debugen_in)
            $write("%0t state=%s valid=%b ready=%b wr=%b addr=%h data=%h\n", $time,
                   state_q.name(), req_valid_in, req_ready_out, write_q, waddr_q, wdata_q);
    end
`endif

endmodule

// File: tb/tb_file_write_arbiter.sv
// Directed self-checking bench for file_write_arbiter: clear sweep, round-robin
// grants, init restart, mid-sweep reset and the optional stall counter.
module tb_file_write_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 32;
    localparam int MEM_DEPTH  = 256;

    logic                          clk = 1'b0;
    logic                          reset = 1'b0;
    logic [NUM_REQ-1:0]            req_valid_in = '0;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in = '0;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in = '0;
    logic [NUM_REQ-1:0]            req_ready_out;
    logic                          init_in = 1'b0;
    logic                          busy_out;
    logic [1:0]                    grant_id_out;
    logic [ADDR_WIDTH-1:0]         write_addr_out;
    logic                          write_out;
    logic [DATA_WIDTH-1:0]         write_data_out;
    logic [15:0]                   stall_count_out;
    logic                          debugen_in = 1'b0;

    int checks = 0;
    int failures = 0;

    file_write_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid_in(req_valid_in), .req_addr_in(req_addr_in), .req_data_in(req_data_in),
        .req_ready_out(req_ready_out), .init_in(init_in), .busy_out(busy_out),
        .grant_id_out(grant_id_out), .write_addr_out(write_addr_out), .write_out(write_out),
        .write_data_out(write_data_out), .stall_count_out(stall_count_out),
        .debugen_in(debugen_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Leaves the bench 1 time unit after a rising edge, away from the edge itself.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called when the DUT is in CLEAR with clr_addr=0; the next edge issues address 0.
    task automatic sweep_check(input string tag);
        for (int k = 0; k < MEM_DEPTH; k++) begin
            tick();
            check({tag, "_wr"},   32'(write_out), 32'd1);
            check({tag, "_addr"}, 32'(write_addr_out), 32'(k));
            check({tag, "_data"}, write_data_out, 32'd0);
            check({tag, "_busy"}, 32'(busy_out), (k != MEM_DEPTH - 1) ? 32'd1 : 32'd0);
            if (k != MEM_DEPTH - 1)
                check({tag, "_rdy0"}, 32'(req_ready_out), 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(8'h20 + i);
            req_data_in[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(32'h10 + i);
        end

        // Reset state
        #12;
        check("rst_wr",    32'(write_out), 32'd0);
        check("rst_addr",  32'(write_addr_out), 32'd0);
        check("rst_data",  write_data_out, 32'd0);
        check("rst_gid",   32'(grant_id_out), 32'd0);
        check("rst_stall", 32'(stall_count_out), 32'd0);
        check("rst_busy",  32'(busy_out), 32'd1);
        check("rst_rdy",   32'(req_ready_out), 32'd0);

        // Release reset with all requesters valid: sweep must keep ready low
        @(posedge clk); #1;
        reset = 1'b1;
        req_valid_in = 4'b1111;
        sweep_check("sweep1");

        // All four valid: round-robin 0,1,2,3,0
        for (int j = 0; j < 5; j++) begin
            check("rr_rdy", 32'(req_ready_out), 32'(1 << (j % 4)));
            tick();
            check("rr_wr",   32'(write_out), 32'd1);
            check("rr_data", write_data_out, 32'h10 + 32'(j % 4));
            check("rr_addr", 32'(write_addr_out), 32'h20 + 32'(j % 4));
            check("rr_gid",  32'(grant_id_out), 32'(j % 4));
        end

        // Only requester 2 valid for three back-to-back writes
        req_valid_in = 4'b0100;
        for (int a = 5; a < 8; a++) begin
            req_addr_in[2*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(a);
            req_data_in[2*DATA_WIDTH +: DATA_WIDTH] = 32'h100 + 32'(a);
            #1;
            check("r2_rdy", 32'(req_ready_out), 32'b0100);
            tick();
            check("r2_wr",   32'(write_out), 32'd1);
            check("r2_addr", 32'(write_addr_out), 32'(a));
            check("r2_data", write_data_out, 32'h100 + 32'(a));
            check("r2_gid",  32'(grant_id_out), 32'd2);
        end

        // Idle: no write, addr/data hold
        req_valid_in = 4'b0000;
        #1;
        check("idle_rdy", 32'(req_ready_out), 32'd0);
        tick();
        check("idle_wr",   32'(write_out), 32'd0);
        check("idle_addr", 32'(write_addr_out), 32'd7);
        check("idle_data", write_data_out, 32'h107);

        // init_in with requesters 0 and 1 valid: no grant, sweep restarts
        req_valid_in = 4'b0011;
        init_in = 1'b1;
        #1;
        check("init_rdy", 32'(req_ready_out), 32'd0);
        tick();
        init_in = 1'b0;
        check("init_wr",   32'(write_out), 32'd0);
        check("init_busy", 32'(busy_out), 32'd1);
        check("init_gid",  32'(grant_id_out), 32'd2);
        sweep_check("sweep2");
        // rr_ptr is 3 after the requester-2 writes; 3 is idle so 0 wins
        check("post_init_rdy", 32'(req_ready_out), 32'b0001);
        check("post_init_stall", 32'(stall_count_out), 32'd0);

        // Stall counter: three requesters valid for ten cycles, one stall count per cycle
        req_valid_in = 4'b0111;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("stall_wr", 32'(write_out), 32'd1);
        end
        req_valid_in = 4'b0000;
`ifdef FILE_WRITE_ARBITER_STALL_CNT_EN
        check("stall_cnt", 32'(stall_count_out), 32'd10);
`else
        check("stall_cnt", 32'(stall_count_out), 32'd0);
`endif
        tick();
`ifdef FILE_WRITE_ARBITER_STALL_CNT_EN
        check("stall_hold", 32'(stall_count_out), 32'd10);
`else
        check("stall_hold", 32'(stall_count_out), 32'd0);
`endif

        // Reset one cycle mid-sweep at clr_addr=0x80
        init_in = 1'b1;
        tick();
        init_in = 1'b0;
        for (int k = 0; k < 8'h80; k++) tick();
        check("mid_addr", 32'(write_addr_out), 32'h7F);
        check("mid_wr",   32'(write_out), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_wr",    32'(write_out), 32'd0);
        check("mid_rst_addr",  32'(write_addr_out), 32'd0);
        check("mid_rst_busy",  32'(busy_out), 32'd1);
        check("mid_rst_gid",   32'(grant_id_out), 32'd0);
        check("mid_rst_stall", 32'(stall_count_out), 32'd0);
        tick();
        reset = 1'b1;
        sweep_check("sweep3");

        // rr_ptr was reset to 0: requesters 1 and 3 valid picks 1
        req_valid_in = 4'b1010;
        #1;
        check("post_rst_rdy", 32'(req_ready_out), 32'b0010);
        tick();
        check("post_rst_gid", 32'(grant_id_out), 32'd1);
        check("post_rst_data", write_data_out, 32'h11);
        req_valid_in = 4'b0000;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, failures=%0d", failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/file_write_arbiter.md
Name: file_write_arbiter

Overview:
- Shares the single write port of the 2-read/1-write register file among NUM_REQ requesters using round-robin arbitration with a valid/ready handshake.
- After reset, and on request, it runs a clear sweep that writes zero to every file entry. The file itself therefore needs no reset loop.
- Sits directly in front of the file. Its write outputs connect one-to-one to the file's write_addr_in, write_in and write_data_in.

Parameters:
- NUM_REQ, 4, number of requesters; power of two, 2..8.
- ADDR_WIDTH, 8, file address width.
- DATA_WIDTH, 32, file data width.
- MEM_DEPTH, 256, file entries; must be at most 2**ADDR_WIDTH.

Ports:
- clk  input  1  clock; one clock, all logic on posedge.
- reset  input  1  reset; asynchronous and active-low (0 = in reset).
- req_valid_in  input  NUM_REQ  per-requester write request.
- req_addr_in  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i.
- req_data_in  input  NUM_REQ*DATA_WIDTH  packed data; requester i occupies slice i.
- req_ready_out  output  NUM_REQ  one-hot grant; all zero when not granting.
- init_in  input  1  pulse that starts a clear sweep.
- busy_out  output  1  high while the clear sweep runs.
- grant_id_out  output  $clog2(NUM_REQ)  index of the last accepted requester, registered.
- write_addr_out  output  ADDR_WIDTH  to file write_addr_in.
- write_out  output  1  to file write_in.
- write_data_out  output  DATA_WIDTH  to file write_data_in.
- stall_count_out  output  16  see Optional Feature.
- debugen_in  input  1  enables the per-cycle $write trace line.

Behaviour:
- States:
  - CLEAR: sweep counter clr_addr.
  - ARB: normal arbitration.
- Reset asserted, at any time including mid-sweep or mid-transfer:
  - state=CLEAR, clr_addr=0, rr_ptr=0.
  - write_out=0, write_addr_out=0, write_data_out=0, grant_id_out=0, stall_count_out=0.
  - busy_out=1.
- CLEAR state:
  - Each cycle registers write_out=1, write_addr_out=clr_addr, write_data_out=0, then increments clr_addr.
  - After the cycle that issues address MEM_DEPTH-1, moves to ARB. busy_out falls in the same edge.
  - The sweep takes exactly MEM_DEPTH cycles.
  - req_ready_out=0 throughout.
  - init_in in CLEAR restarts the sweep: clr_addr=0.
- ARB state, grant:
  - req_ready_out is combinational: one-hot on the first requester with req_valid_in=1, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - No valid request gives all zeros.
- ARB state, transfer:
  - A transfer happens when valid and ready are both 1 on the same edge.
  - The following cycle registers write_out=1 with that requester's addr/data. Latency is 1 cycle from handshake to the file write.
  - grant_id_out is set to the granted index.
  - rr_ptr becomes granted index+1 modulo NUM_REQ.
  - No transfer gives write_out=0; addr/data hold their last value.
- Throughput: one write per cycle. Back-to-back grants to the same requester are allowed only if no other requester is valid.
- Requester rules:
  - req_valid_in must not depend combinationally on req_ready_out.
  - Addr/data must be held stable while valid and not ready.
- init_in in ARB:
  - Suppresses grants that cycle (ready all zero).
  - Enters CLEAR next edge with clr_addr=0.
  - Any write registered in the same edge is still issued.
- Out-of-range addresses (≥MEM_DEPTH) are passed through unchecked.
- debugen_in=1: one $write per cycle with state, req_valid_in, req_ready_out, write_out, write_addr_out, write_data_out.

Optional Feature:
- Macro: FILE_WRITE_ARBITER_STALL_CNT_EN.
- Defined:
  - stall_count_out is a 16-bit saturating counter.
  - It increments on each ARB cycle where at least one requester has valid=1 and ready=0.
  - It counts once per cycle, not once per requester.
  - It stays at 0xFFFF once reached and is cleared by reset or init_in.
- Undefined: stall_count_out is tied to 0, with no counter flops.

Test Plan:
- Release reset at cycle 0 with MEM_DEPTH=256 -> write_out=1 for 256 consecutive cycles, addr 0..255, data 0. busy_out falls after the addr-255 write and ready stays 0 before that.
- In ARB, hold all 4 valid with data 0x10+i -> grants cycle 0,1,2,3,0; write_data_out is 0x10,0x11,0x12,0x13,0x10 one cycle after each handshake.
- Only requester 2 valid for 3 cycles (addr 0x05/0x06/0x07) -> ready=4'b0100 each cycle; three consecutive writes; grant_id_out=2.
- Pulse init_in while requesters 0 and 1 are valid -> no ready that cycle; CLEAR restarts at addr 0; ready stays 0 for 256 cycles.
- Assert reset for 1 cycle mid-sweep at clr_addr=0x80 -> write_out drops immediately; after release the sweep restarts from 0.
- With FILE_WRITE_ARBITER_STALL_CNT_EN, 3 requesters valid for 10 cycles -> stall_count_out=10. Without the macro it reads 0.
